// File: rtl/genius_controller.sv
// Game-flow controller for the Genius memory game: a Moore FSM that drives datapath resets and enables.
// Optional build macro GENIUS_RESULT_TIMEOUT_EN adds an automatic return from RESULT after RESULT_TIMEOUT cycles.
module genius_controller #(
    parameter logic [31:0] RESULT_TIMEOUT = 32'd250_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enter,
    input  logic       end_FPGA,
    input  logic       end_User,
    input  logic       end_time,
    input  logic       win,
    input  logic       match,
    output logic       R1,
    output logic       R2,
    output logic       E1,
    output logic       E2,
    output logic       E3,
    output logic       E4,
    output logic       SEL,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        SETUP      = 3'd1,
        PLAY_FPGA  = 3'd2,
        PLAY_USER  = 3'd3,
        CHECK      = 3'd4,
        NEXT_ROUND = 3'd5,
        RESULT     = 3'd6
    } state_t;

    state_t state;
    state_t next_state;
    logic   enter_q;
    logic   enter_rise;

    assign enter_rise = enter & ~enter_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state   <= INIT;
            enter_q <= 1'b0;
        end else begin
            state   <= next_state;
            enter_q <= enter;
        end
    end

`ifdef GENIUS_RESULT_TIMEOUT_EN
    logic [31:0] result_count;
    logic        timeout_hit;

    // Clears whenever the FSM is outside RESULT, so it is zero in the first RESULT cycle.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            result_count <= 32'd0;
        end else if (state != RESULT) begin
            result_count <= 32'd0;
        end else begin
            result_count <= result_count + 32'd1;
        end
    end

    assign timeout_hit = (state == RESULT) && (result_count == RESULT_TIMEOUT - 32'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^RESULT_TIMEOUT;
`endif

    // NOTE: next_state gets a default first so no path through the case can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            INIT:      next_state = SETUP;
            SETUP:     if (enter_rise) next_state = PLAY_FPGA;
            PLAY_FPGA: if (end_FPGA) next_state = PLAY_USER;
            PLAY_USER: begin
                if (end_time) begin
                    next_state = RESULT;
                end else if (end_User) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (!match || win) begin
                    next_state = RESULT;
                end else begin
                    next_state = NEXT_ROUND;
                end
            end
            NEXT_ROUND: next_state = PLAY_FPGA;
            RESULT: begin
                if (enter_rise) begin
                    next_state = INIT;
`ifdef GENIUS_RESULT_TIMEOUT_EN
                end else if (timeout_hit) begin
                    next_state = INIT;
`endif
                end
            end
            default: next_state = INIT;
        endcase
    end

    always_comb begin
        R1  = 1'b0;
        R2  = 1'b0;
        E1  = 1'b0;
        E2  = 1'b0;
        E3  = 1'b0;
        E4  = 1'b0;
        SEL = 1'b0;
        case (state)
            INIT: begin
                R1 = 1'b1;
                R2 = 1'b1;
            end
            SETUP:     E1 = 1'b1;
            PLAY_FPGA: E3 = 1'b1;
            PLAY_USER: E2 = 1'b1;
            NEXT_ROUND: begin
                R2 = 1'b1;
                E4 = 1'b1;
            end
            RESULT:    SEL = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: doc/genius_controller.md
GENIUS_CONTROLLER -- requirements
Module: genius_controller

Interface
REQ-001 Parameter RESULT_TIMEOUT, default 32'd250_000_000, meaning CLOCK_50 cycles spent in RESULT before auto-return (used only with GENIUS_RESULT_TIMEOUT_EN).
REQ-002 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enter  input  1  synchronized start/confirm button, active-high level.
REQ-005 end_FPGA  input  1  FPGA sequence playback finished.
REQ-006 end_User  input  1  user entered a full round of inputs.
REQ-007 end_time  input  1  user time limit expired.
REQ-008 win  input  1  final round reached.
REQ-009 match  input  1  user sequence equals FPGA sequence.
REQ-010 R1  output  1  setup/round reset to datapath, active-high.
REQ-011 R2  output  1  per-round reset (timer, user, FPGA counters), active-high.
REQ-012 E1, E2, E3, E4  output  1 each  setup load, user/timer enable, FPGA playback enable, round increment.
REQ-013 SEL  output  1  display select: 0 = game display, 1 = result display.
REQ-014 state_o  output  3  current state code for debug and bench.

Function
REQ-015 Moore FSM; state codes INIT=0, SETUP=1, PLAY_FPGA=2, PLAY_USER=3, CHECK=4, NEXT_ROUND=5, RESULT=6; code 7 goes to INIT on the next edge.
REQ-016 Outputs are decoded only from the state register; they are valid in the first cycle of a state. No input reaches an output combinationally.
REQ-017 Output map; unlisted outputs are 0:
- INIT: R1=1, R2=1.
- SETUP: E1=1.
- PLAY_FPGA: E3=1.
- PLAY_USER: E2=1.
- CHECK: none.
- NEXT_ROUND: R2=1, E4=1.
- RESULT: SEL=1.
REQ-018 enter is edge-detected with a registered copy. enter_rise = enter & ~enter_q. A level held across states never produces a second event.
REQ-019 Transition INIT->SETUP is unconditional after one cycle.
REQ-020 Transition SETUP->PLAY_FPGA on enter_rise; otherwise stay in SETUP.
REQ-021 Transition PLAY_FPGA->PLAY_USER when end_FPGA=1.
REQ-022 PLAY_USER transitions:
- end_time=1 -> RESULT. end_time has priority over end_User when both are asserted in the same cycle.
- else end_User=1 -> CHECK.
- else stay in PLAY_USER.
REQ-023 CHECK transitions:
- match=0 -> RESULT.
- match=1 and win=1 -> RESULT.
- match=1 and win=0 -> NEXT_ROUND.
REQ-024 Transition NEXT_ROUND->PLAY_FPGA is unconditional after exactly one cycle, so E4 is one pulse per round.
REQ-025 Transition RESULT->INIT on enter_rise.
REQ-026 Inputs to the FSM are sampled only in the states named above; asserting them in any other state has no effect.

Reset
REQ-027 While reset=0, state=INIT and enter_q=0, giving R1=1, R2=1, E1..E4=0, SEL=0, state_o=0. When GENIUS_RESULT_TIMEOUT_EN is defined, timeout counter=0.
REQ-028 Reset assertion mid-game forces INIT asynchronously, without waiting for a clock edge.
REQ-029 After reset deasserts, the first rising edge moves INIT->SETUP.

Configuration
REQ-030 Macro GENIUS_RESULT_TIMEOUT_EN, when defined:
- A 32-bit counter clears on RESULT entry and increments each cycle in RESULT.
- When the count reaches RESULT_TIMEOUT-1, the FSM goes to INIT on the next edge.
- enter_rise still exits RESULT immediately and wins if both occur in the same cycle.
REQ-031 Without GENIUS_RESULT_TIMEOUT_EN, no counter exists and RESULT exits only on enter_rise.

Verification
REQ-032 Reset, then release; hold enter=0 -> state_o goes 0 then 1 and stays 1; R1=R2=1 only during INIT.
REQ-033 Full round, win path:
- Stimulus: enter pulse; end_FPGA after 5 cycles; end_User after 10; match=1, win=0.
- Required: state_o sequence 1,2,3,4,5,2; E4 high exactly 1 cycle.
- Then win=1 on the next CHECK -> state_o=6, SEL=1.
REQ-034 Loss and tie-break:
- In PLAY_USER, assert end_time=1 and end_User=1 in the same cycle -> state_o=6, never 4.
- In CHECK with match=0, win=1 -> state_o=6.
REQ-035 Enter handling: hold enter=1 from SETUP through RESULT -> only one transition out of SETUP; FSM stays in RESULT until enter drops and rises again, then state_o=0.
REQ-036 With GENIUS_RESULT_TIMEOUT_EN and RESULT_TIMEOUT=8:
- No enter -> RESULT lasts exactly 8 cycles, then state_o=0.
- Without the macro, same stimulus -> state_o stays 6 for 100 cycles.
REQ-037 Assert reset=0 mid-PLAY_FPGA, between clock edges -> state_o=0, E3=0, R1=R2=1 immediately, before the next edge.
